// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - format codes, opcode map and immediate decode for imm_gen_pipe
package imm_gen_pkg;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [31:0] imm;
  } dec_t;

  // Shift-immediates stay raw I-type: funct7 lands in imm[11:5] untouched.
  function automatic dec_t decode_imm(input logic [31:0] instr);
    dec_t d;
    d.fmt = FMT_NONE;
    d.imm = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
        d.fmt = FMT_I;
        d.imm = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        d.fmt = FMT_S;
        d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        d.fmt = FMT_B;
        d.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        d.fmt = FMT_U;
        d.imm = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        d.fmt = FMT_J;
        d.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP: begin
        d.fmt = FMT_R;
        d.imm = '0;
      end
      default: begin
        d.fmt = FMT_NONE;
        d.imm = '0;
      end
    endcase
    return d;
  endfunction

  // JALR is excluded: its target depends on rs1, which never reaches this block.
  function automatic logic has_target(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - one elastic valid/ready register slice with flush
module imm_gen_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         v;
  logic [W-1:0] data;
  logic         adv;

  assign adv       = !v || out_ready;
  assign in_ready  = flush || adv;
  assign out_valid = v;
  assign out_data  = data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= 1'b0;
      data <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (adv) begin
      v <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - elastic ID-stage immediate generator with pc-relative target
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_tgt_vld,
  output logic            out_illegal
);

  // aux carries the pc between stages when the add is deferred, else the target.
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] aux;
    logic            tgt_vld;
    logic            illegal;
  } pay_t;

  localparam int PW = $bits(pay_t);

  dec_t            dec;
  logic [XLEN-1:0] imm_x;
  logic            tv;
  pay_t            s0_in;
  pay_t            s0_out;
  pay_t            last_out;
  logic            s0_valid;
  logic            s0_ready_dn;
  logic            last_valid;

  always_comb begin
    dec   = decode_imm(in_instr);
    imm_x = XLEN'($signed(dec.imm));
    tv    = has_target(in_instr[6:0]);
    s0_in.imm     = imm_x;
    s0_in.fmt     = dec.fmt;
    s0_in.tgt_vld = tv;
    s0_in.illegal = (dec.fmt == FMT_NONE);
    if (PIPE_STAGES == 1) begin
      s0_in.aux = tv ? in_pc + imm_x : '0;
    end else begin
      s0_in.aux = in_pc;
    end
  end

  imm_gen_stage #(.W(PW)) u_s0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s0_in),
    .out_valid (s0_valid),
    .out_ready (s0_ready_dn),
    .out_data  (s0_out)
  );

  generate
    if (PIPE_STAGES == 2) begin : g_two
      pay_t s1_in;

      always_comb begin
        s1_in     = s0_out;
        s1_in.aux = s0_out.tgt_vld ? s0_out.aux + s0_out.imm : '0;
      end

      imm_gen_stage #(.W(PW)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (s0_valid),
        .in_ready  (s0_ready_dn),
        .in_data   (s1_in),
        .out_valid (last_valid),
        .out_ready (out_ready),
        .out_data  (last_out)
      );
    end else begin : g_one
      assign s0_ready_dn = out_ready;
      assign last_valid  = s0_valid;
      assign last_out    = s0_out;
    end
  endgenerate

  assign out_valid   = last_valid;
  assign out_imm     = last_out.imm;
  assign out_fmt     = last_out.fmt;
  assign out_target  = last_out.aux;
  assign out_tgt_vld = last_out.tgt_vld;
  assign out_illegal = last_out.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized scoreboard bench for imm_gen_pipe
module tb_imm_gen_pipe;

  parameter int PIPE_STAGES = 1;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_target;
  logic        out_tgt_vld;
  logic        out_illegal;

  imm_gen_pipe #(.XLEN(XLEN), .PIPE_STAGES(PIPE_STAGES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_target  (out_target),
    .out_tgt_vld (out_tgt_vld),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] target;
    logic        tv;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        acc = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] sv_imm;
  logic [31:0] sv_tgt;
  logic [2:0]  sv_fmt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Field arithmetic straight from the RV32I immediate layouts.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic [31:0] neg;
    logic [31:0] opc;
    neg = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    opc = ins & 32'h7f;
    e.imm = 32'h0;
    e.fmt = 3'd7;
    if (opc == 32'h03 || opc == 32'h13 || opc == 32'h67 || opc == 32'h73) begin
      e.fmt = 3'd1;
      e.imm = (neg << 12) | (ins >> 20);
    end else if (opc == 32'h23) begin
      e.fmt = 3'd2;
      e.imm = (neg << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'd31);
    end else if (opc == 32'h63) begin
      e.fmt = 3'd3;
      e.imm = (neg << 12) | (((ins >> 7) & 32'd1) << 11) | (((ins >> 25) & 32'd63) << 5)
            | (((ins >> 8) & 32'd15) << 1);
    end else if (opc == 32'h37 || opc == 32'h17) begin
      e.fmt = 3'd4;
      e.imm = ins & 32'hFFFF_F000;
    end else if (opc == 32'h6f) begin
      e.fmt = 3'd5;
      e.imm = (neg << 20) | (((ins >> 12) & 32'd255) << 12) | (((ins >> 20) & 32'd1) << 11)
            | (((ins >> 21) & 32'd1023) << 1);
    end else if (opc == 32'h33) begin
      e.fmt = 3'd0;
    end
    e.ill    = (e.fmt == 3'd7);
    e.tv     = (opc == 32'h63 || opc == 32'h6f || opc == 32'h17);
    e.target = e.tv ? pc + e.imm : 32'h0;
    return e;
  endfunction

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    exp_t e;
    #3;
    check("in_ready", 64'(in_ready), 64'(flush || out_ready || (q.size() < PIPE_STAGES)));
    if (stall_prev) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", {sv_imm, sv_tgt}, {out_imm, out_target});
      check("stall_fmt", 64'(sv_fmt), 64'(out_fmt));
    end
    if (out_valid) check("valid_has_entry", 64'(q.size() != 0), 64'd1);
    if (out_valid && out_ready && q.size() != 0) begin
      e = q.pop_front();
      check("imm", 64'(out_imm), 64'(e.imm));
      check("target", {31'b0, out_tgt_vld, out_target}, {31'b0, e.tv, e.target});
      check("fmt", {out_illegal, out_fmt}, {e.ill, e.fmt});
    end
    acc = in_valid && in_ready && !flush;
    if (flush) q.delete();
    if (acc) q.push_back(ref_model(in_instr, in_pc));
    stall_prev = out_valid && !out_ready && !flush;
    sv_imm = out_imm;
    sv_tgt = out_target;
    sv_fmt = out_fmt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] eimm, input logic [2:0] efmt,
                          input logic [31:0] etgt, input logic etv, input logic eill);
    int lat;
    flush = 1'b0;
    out_ready = 1'b1;
    in_instr = ins;
    in_pc = pc;
    in_valid = 1'b1;
    cycle();
    check({tag, "_accept"}, 64'(acc), 64'd1);
    in_valid = 1'b0;
    for (lat = 1; lat <= 8; lat++) begin
      #1;
      if (out_valid) break;
      cycle();
    end
    check({tag, "_latency"}, 64'(lat), 64'(PIPE_STAGES));
    check({tag, "_imm"}, 64'(out_imm), 64'(eimm));
    check({tag, "_fmt"}, {out_illegal, out_fmt}, {eill, efmt});
    check({tag, "_tgt"}, {out_tgt_vld, out_target}, {etv, etgt});
    cycle();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [11];
    logic [31:0] r;
    opcs = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h00};
    r = $urandom();
    return {r[31:7], (r[3:0] < 4'd11) ? opcs[r[3:0]] : 7'(r[6:0])};
  endfunction

  initial begin
    logic [31:0] arr [4];
    int          idx;
    int          guard;

    rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_outputs", {out_imm, out_target}, 64'd0);
    check("rst_flags", {out_fmt, out_tgt_vld, out_illegal}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    directed("lw",    32'hFFC12083, 32'h0000_0040, 32'hFFFF_FFFC, 3'd1, 32'h0,        1'b0, 1'b0);
    directed("beq",   32'hFE000CE3, 32'h0000_0100, 32'hFFFF_FFF8, 3'd3, 32'h0000_00F8, 1'b1, 1'b0);
    directed("jal",   32'h001000EF, 32'h0000_1000, 32'h0000_0800, 3'd5, 32'h0000_1800, 1'b1, 1'b0);
    directed("jalw",  32'h001000EF, 32'hFFFF_F800, 32'h0000_0800, 3'd5, 32'h0000_0000, 1'b1, 1'b0);
    directed("lui",   32'h123452B7, 32'h0000_0200, 32'h1234_5000, 3'd4, 32'h0,        1'b0, 1'b0);
    directed("ill",   32'h0000007F, 32'h0000_0300, 32'h0,         3'd7, 32'h0,        1'b0, 1'b1);
    directed("auipc", 32'h00001017, 32'h0000_0010, 32'h0000_1000, 3'd4, 32'h0000_1010, 1'b1, 1'b0);
    directed("jalr",  32'h004080E7, 32'h0000_0500, 32'h0000_0004, 3'd1, 32'h0,        1'b0, 1'b0);
    directed("sw",    32'hFE112E23, 32'h0000_0600, 32'hFFFF_FFFC, 3'd2, 32'h0,        1'b0, 1'b0);
    directed("add",   32'h002081B3, 32'h0000_0700, 32'h0,         3'd0, 32'h0,        1'b0, 1'b0);

    // Backpressure: four entries, consumer stalled for the first three cycles.
    for (int i = 0; i < 4; i++) arr[i] = rand_instr();
    idx = 0;
    guard = 0;
    while (idx < 4 && guard < 50) begin
      in_valid = 1'b1;
      in_instr = arr[idx];
      in_pc = 32'h2000 + 32'(idx * 4);
      out_ready = (guard >= 3);
      if (!out_ready && idx == PIPE_STAGES) begin
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
      end
      cycle();
      if (acc) idx++;
      guard++;
    end
    check("bp_all_accepted", 64'(idx), 64'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      cycle();
      guard++;
    end
    check("bp_drained", 64'(q.size()), 64'd0);

    // Flush with the pipe full and a new input offered.
    out_ready = 1'b0;
    in_valid = 1'b1;
    guard = 0;
    while (q.size() < PIPE_STAGES && guard < 20) begin
      in_instr = rand_instr();
      in_pc = $urandom();
      cycle();
      guard++;
    end
    check("flush_full", 64'(q.size()), 64'(PIPE_STAGES));
    flush = 1'b1;
    in_instr = 32'h001000EF;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (3) cycle();
    check("flush_not_emitted", 64'(out_valid), 64'd0);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      if (!(in_valid && !acc)) begin
        in_instr = rand_instr();
        in_pc = $urandom();
      end
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 59) == 0);
      cycle();
    end
    flush = 1'b0;

    // Asynchronous reset mid-stream.
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8 && !out_valid; k++) begin
      in_instr = rand_instr();
      in_pc = $urandom();
      cycle();
    end
    check("rst_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_outputs", {out_imm, out_target}, 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    stall_prev = 1'b0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) cycle();
    check("arst_stays_empty", 64'(out_valid), 64'd0);

    directed("post_rst", 32'hFE000CE3, 32'h0000_0100, 32'hFFFF_FFF8, 3'd3, 32'h0000_00F8, 1'b1, 1'b0);

    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      cycle();
      guard++;
    end
    check("final_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
